// File: rtl/and_gate.sv
// Bitwise two-operand AND with a zero-latency result and a one-cycle registered copy
// carrying valid and reduction flags. Define AND_GATE_HIT_COUNT_EN to build the all-ones hit counter.
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             all_ones,
  output logic             any_one,
  output logic [CNT_W-1:0] hit_count
);

  // Pure continuous assignment so the gate works with no clock running.
  assign y = a & b;

  logic [WIDTH-1:0] res_q, res_d;
  logic             valid_q, valid_d;
  logic             all_q, all_d;
  logic             any_q, any_d;

  always_comb begin
    res_d   = res_q;
    all_d   = all_q;
    any_d   = any_q;
    valid_d = 1'b0;
    if (in_valid) begin
      res_d   = y;
      all_d   = &y;
      any_d   = |y;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      valid_q <= 1'b0;
      all_q   <= 1'b0;
      any_q   <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
      all_q   <= all_d;
      any_q   <= any_d;
    end
  end

  assign y_q       = res_q;
  assign out_valid = valid_q;
  assign all_ones  = all_q;
  assign any_one   = any_q;

`ifdef AND_GATE_HIT_COUNT_EN
  logic [CNT_W-1:0] hit_q, hit_d;

  // Saturating: once all ones the count stays put.
  always_comb begin
    hit_d = hit_q;
    if (in_valid && (&y) && !(&hit_q)) begin
      hit_d = hit_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= '0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hit_count = hit_q;
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: one WIDTH=1 and one WIDTH=8 instance sharing clock and control,
// checked each cycle against a behavioural model plus hand-computed literal expectations.
module tb_and_gate;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          chk_en = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [0:0]    a1 = '0, b1 = '0;
  logic [7:0]    a8 = '0, b8 = '0;

  logic [0:0]    y1, yq1;
  logic [7:0]    y8, yq8;
  logic          ov1, all1, any1, ov8, all8, any8;
  logic [CW-1:0] hc1, hc8;

  int errors = 0;
  int checks = 0;

  and_gate #(.WIDTH(1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(in_valid),
    .y(y1), .y_q(yq1), .out_valid(ov1), .all_ones(all1), .any_one(any1), .hit_count(hc1)
  );

  and_gate #(.WIDTH(8), .CNT_W(CW)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid),
    .y(y8), .y_q(yq8), .out_valid(ov8), .all_ones(all8), .any_one(any8), .hit_count(hc8)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model state: what each registered output must be, from the behavioural rules.
  int m_yq1, m_yq8, m_hc1, m_hc8;
  bit m_ov, m_all1, m_any1, m_all8, m_any8;

  function automatic int sat_inc(input int v);
    return (v == (1 << CW) - 1) ? v : v + 1;
  endfunction

  always @(posedge clk) begin
    int r1, r8;
    r1 = int'(a1) & int'(b1);
    r8 = int'(a8) & int'(b8);
    if (rst) begin
      m_yq1 = 0; m_yq8 = 0; m_ov = 0;
      m_all1 = 0; m_any1 = 0; m_all8 = 0; m_any8 = 0;
      m_hc1 = 0; m_hc8 = 0;
    end else if (in_valid) begin
      m_yq1 = r1; m_yq8 = r8; m_ov = 1;
      m_all1 = (r1 == 1); m_any1 = (r1 != 0);
      m_all8 = (r8 == 255); m_any8 = (r8 != 0);
`ifdef AND_GATE_HIT_COUNT_EN
      if (r1 == 1) m_hc1 = sat_inc(m_hc1);
      if (r8 == 255) m_hc8 = sat_inc(m_hc8);
`endif
    end else begin
      m_ov = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("y1_live", 64'(y1), 64'(a1 & b1));
      check("y8_live", 64'(y8), 64'(a8 & b8));
      check("y_q1", 64'(yq1), 64'(m_yq1));
      check("y_q8", 64'(yq8), 64'(m_yq8));
      check("out_valid1", 64'(ov1), 64'(m_ov));
      check("out_valid8", 64'(ov8), 64'(m_ov));
      check("all_ones1", 64'(all1), 64'(m_all1));
      check("any_one1", 64'(any1), 64'(m_any1));
      check("all_ones8", 64'(all8), 64'(m_all8));
      check("any_one8", 64'(any8), 64'(m_any8));
      check("hit_count1", 64'(hc1), 64'(m_hc1));
      check("hit_count8", 64'(hc8), 64'(m_hc8));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic [7:0] av, input logic [7:0] bv);
    in_valid = v; a8 = av; b8 = bv;
    a1 = av[0]; b1 = bv[0];
  endtask

  initial begin
    logic [1:0] ab_vec [4];
    logic [0:0] y_exp [4];
    logic [CW-1:0] hc_exp [5];
    ab_vec = '{2'b00, 2'b01, 2'b10, 2'b11};
    y_exp  = '{1'b0, 1'b0, 1'b0, 1'b1};
`ifdef AND_GATE_HIT_COUNT_EN
    hc_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
    hc_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif

    // Unclocked combinational path.
    for (int i = 0; i < 4; i++) begin
      a1 = ab_vec[i][1];
      b1 = ab_vec[i][0];
      #1;
      check("comb_noclk_y1", 64'(y1), 64'(y_exp[i]));
      $display("comb a=%b b=%b y=%b", a1, b1, y1);
      #9;
    end

    // Two reset cycles with valid all-ones inputs.
    rst = 1'b1;
    drive8(1'b1, 8'hFF, 8'hFF);
    clk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_en = 1'b1;
      check("rst_y1_comb", 64'(y1), 64'(1));
      check("rst_y8_comb", 64'(y8), 64'hFF);
      check("rst_yq8", 64'(yq8), 64'h0);
      check("rst_ov8", 64'(ov8), 64'(0));
      check("rst_all8", 64'(all8), 64'(0));
      check("rst_any8", 64'(any8), 64'(0));
      check("rst_hc8", 64'(hc8), 64'(0));
      $display("reset cycle %0d y_q=%h out_valid=%b", i, yq8, ov8);
    end
    rst = 1'b0;

    // Capture F0 & 3C, then hold for 3 idle cycles with changing operands.
    drive8(1'b1, 8'hF0, 8'h3C);
    tick();
    check("cap30_yq", 64'(yq8), 64'h30);
    check("cap30_any", 64'(any8), 64'(1));
    check("cap30_all", 64'(all8), 64'(0));
    check("cap30_ov", 64'(ov8), 64'(1));
    $display("capture a=F0 b=3C y_q=%h", yq8);
    for (int i = 0; i < 3; i++) begin
      drive8(1'b0, 8'(8'h11 * (i + 3)), 8'hA5);
      #1;
      check("idle_y8_live", 64'(y8), 64'(8'(8'h11 * (i + 3)) & 8'hA5));
      tick();
      check("idle_yq_hold", 64'(yq8), 64'h30);
      check("idle_ov", 64'(ov8), 64'(0));
      $display("idle %0d y=%h y_q=%h", i, y8, yq8);
    end

    drive8(1'b1, 8'hFF, 8'hFF);
    tick();
    check("capFF_yq", 64'(yq8), 64'hFF);
    check("capFF_all", 64'(all8), 64'(1));
    check("capFF_ov", 64'(ov8), 64'(1));
    $display("capture a=FF b=FF y_q=%h all_ones=%b", yq8, all8);
    drive8(1'b0, 8'h00, 8'h00);
    tick();
    check("after_ov", 64'(ov8), 64'(0));

    // Valid all-ones sample colliding with reset is discarded.
    drive8(1'b1, 8'hFF, 8'hFF);
    rst = 1'b1;
    tick();
    check("midrst_yq", 64'(yq8), 64'h0);
    check("midrst_ov", 64'(ov8), 64'(0));
    $display("mid-stream reset y_q=%h out_valid=%b", yq8, ov8);
    rst = 1'b0;
    drive8(1'b0, 8'h00, 8'h00);
    tick();

    // Five accepted all-ones samples exercise counter saturation.
    for (int i = 0; i < 5; i++) begin
      drive8(1'b1, 8'hFF, 8'hFF);
      tick();
      check("hit_sat8", 64'(hc8), 64'(hc_exp[i]));
      $display("hit sample %0d hit_count=%0d", i, hc8);
    end

    // A short mixed tail for the per-cycle model.
    drive8(1'b1, 8'h81, 8'h01); tick();
    check("tail_yq", 64'(yq8), 64'h01);
    drive8(1'b1, 8'h0F, 8'hF0); tick();
    check("tail_any0", 64'(any8), 64'(0));
    drive8(1'b0, 8'h00, 8'h00); tick();
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
